// File: rtl/store_buffer.sv
// Pending-store queue: holds retired stores in order, drains them to data memory, and forwards to loads.
// Optional STORE_BUFFER_COALESCE_EN merges a store into the tail entry when it hits the same word.
module store_buffer #(
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     st_valid,
   output logic                     st_ready,
   input  logic [31:0]              st_address,
   input  logic [31:0]              st_data,
   input  logic [3:0]               st_byte_en,
   output logic                     mem_req,
   input  logic                     mem_ack,
   output logic [31:0]              mem_address,
   output logic [31:0]              mem_data,
   output logic [3:0]               mem_byte_en,
   input  logic                     ld_valid,
   input  logic [31:0]              ld_address,
   output logic                     ld_hit,
   output logic [31:0]              ld_data,
   output logic                     ld_stall,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [29:0]   addr_q [DEPTH];
   logic [31:0]   data_q [DEPTH];
   logic [3:0]    be_q   [DEPTH];
   logic [AW-1:0] head_q, tail_q, tail_last;
   logic [CW-1:0] count_q;
   logic          push, pop, merge, alloc;
   logic          match_found;
   logic [AW-1:0] match_idx;

   assign empty     = (count_q == '0);
   assign full      = (count_q == CW'(DEPTH));
   assign count     = count_q;
   assign st_ready  = !full;
   assign push      = st_valid && !full;
   assign pop       = !empty && mem_ack;
   assign tail_last = tail_q - 1'b1;

`ifdef STORE_BUFFER_COALESCE_EN
   assign merge = push && (addr_q[tail_last] == st_address[31:2]) &&
                  (count_q >= CW'(2)) && !(pop && (head_q == tail_last));
`else
   assign merge = 1'b0;
`endif
   assign alloc = push && !merge;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (pop)   head_q <= head_q + 1'b1;
         if (alloc) tail_q <= tail_q + 1'b1;
         case ({alloc, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // NOTE: the entry array has no reset; every reader is gated by occupancy, so stale contents never escape.
   always_ff @(posedge clock) begin
      if (merge) begin
         for (int b = 0; b < 4; b++) begin
            if (st_byte_en[b]) data_q[tail_last][8*b +: 8] <= st_data[8*b +: 8];
         end
         be_q[tail_last] <= be_q[tail_last] | st_byte_en;
      end else if (alloc) begin
         addr_q[tail_q] <= st_address[31:2];
         data_q[tail_q] <= st_data;
         be_q[tail_q]   <= st_byte_en;
      end
   end

   assign mem_req     = !empty;
   assign mem_address = mem_req ? {addr_q[head_q], 2'b00} : 32'h0;
   assign mem_data    = mem_req ? data_q[head_q] : 32'h0;
   assign mem_byte_en = mem_req ? be_q[head_q] : 4'h0;

   // Scan oldest to youngest so the last hit wins, i.e. the youngest matching entry.
   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      match_found = 1'b0;
      match_idx   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if ((CW'(i) < count_q) && (addr_q[head_q + AW'(i)] == ld_address[31:2])) begin
            match_found = 1'b1;
            match_idx   = head_q + AW'(i);
         end
      end
   end

   always_comb begin
      ld_hit   = 1'b0;
      ld_stall = 1'b0;
      ld_data  = 32'h0;
      if (ld_valid && match_found) begin
         if (be_q[match_idx] == 4'hF) begin
            ld_hit  = 1'b1;
            ld_data = data_q[match_idx];
         end else begin
            ld_stall = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: accepted stores are queued in a model and compared as they drain.
// Build with STORE_BUFFER_COALESCE_EN defined to check the merging variant.
module tb_store_buffer;

   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
   } entry_t;

   logic          clock = 1'b0;
   logic          reset;
   logic          st_valid, st_ready;
   logic [31:0]   st_address, st_data;
   logic [3:0]    st_byte_en;
   logic          mem_req, mem_ack;
   logic [31:0]   mem_address, mem_data;
   logic [3:0]    mem_byte_en;
   logic          ld_valid, ld_hit, ld_stall;
   logic [31:0]   ld_address, ld_data;
   logic [CW-1:0] count;
   logic          empty, full;

   entry_t sb[$];
   int     total = 0;
   int     bad   = 0;

   always #5 clock = ~clock;

   store_buffer #(.DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset),
      .st_valid(st_valid), .st_ready(st_ready), .st_address(st_address),
      .st_data(st_data), .st_byte_en(st_byte_en),
      .mem_req(mem_req), .mem_ack(mem_ack), .mem_address(mem_address),
      .mem_data(mem_data), .mem_byte_en(mem_byte_en),
      .ld_valid(ld_valid), .ld_address(ld_address), .ld_hit(ld_hit),
      .ld_data(ld_data), .ld_stall(ld_stall),
      .count(count), .empty(empty), .full(full)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, input logic ack);
      st_valid   = v;
      st_address = a;
      st_data    = d;
      st_byte_en = be;
      mem_ack    = ack;
   endtask

   task automatic query(input logic v, input logic [31:0] a);
      ld_valid   = v;
      ld_address = a;
   endtask

   // Registered status and head presentation against the scoreboard.
   task automatic check_state(input string tag);
      check({tag, "_count"}, 32'(count), 32'(sb.size()));
      check({tag, "_empty"}, 32'(empty), 32'(sb.size() == 0));
      check({tag, "_full"}, 32'(full), 32'(sb.size() == DEPTH));
      check({tag, "_st_ready"}, 32'(st_ready), 32'(sb.size() != DEPTH));
      check({tag, "_mem_req"}, 32'(mem_req), 32'(sb.size() != 0));
      if (sb.size() != 0) begin
         check({tag, "_mem_address"}, mem_address, sb[0].addr);
         check({tag, "_mem_data"}, mem_data, sb[0].data);
         check({tag, "_mem_byte_en"}, 32'(mem_byte_en), 32'(sb[0].be));
      end
   endtask

   task automatic check_query(input string tag);
      logic        h, s;
      logic [31:0] d;
      h = 1'b0;
      s = 1'b0;
      d = 32'h0;
      if (ld_valid) begin
         for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].addr[31:2] == ld_address[31:2]) begin
               if (sb[i].be == 4'hF) begin
                  h = 1'b1;
                  d = sb[i].data;
               end else begin
                  s = 1'b1;
               end
               break;
            end
         end
      end
      check({tag, "_ld_hit"}, 32'(ld_hit), 32'(h));
      check({tag, "_ld_stall"}, 32'(ld_stall), 32'(s));
      check({tag, "_ld_data"}, ld_data, d);
   endtask

   // One clock: predict from pre-edge inputs, update the scoreboard at the edge, then compare at negedge.
   task automatic tick(input string tag);
      logic   acc, pop, mrg;
      entry_t e;
      acc = st_valid && (sb.size() < DEPTH);
      pop = mem_ack && (sb.size() > 0);
      mrg = 1'b0;
`ifdef STORE_BUFFER_COALESCE_EN
      if (acc && sb.size() >= 2 && sb[sb.size()-1].addr[31:2] == st_address[31:2]) mrg = 1'b1;
`endif
      e = '{addr: {st_address[31:2], 2'b00}, data: st_data, be: st_byte_en};
      if (mrg) begin
         e = sb[sb.size()-1];
         for (int b = 0; b < 4; b++) begin
            if (st_byte_en[b]) e.data[8*b +: 8] = st_data[8*b +: 8];
         end
         e.be = e.be | st_byte_en;
      end
      @(posedge clock);
      if (pop) void'(sb.pop_front());
      if (mrg) sb[sb.size()-1] = e;
      else if (acc) sb.push_back(e);
      @(negedge clock);
      check_state(tag);
   endtask

   task automatic drain(input string tag);
      drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
      for (int i = 0; i < DEPTH + 1; i++) tick(tag);
      mem_ack = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      query(1'b1, 32'h0);
      @(negedge clock);
      #1;
      check("rst_st_ready", 32'(st_ready), 32'd1);
      check("rst_mem_address", mem_address, 32'h0);
      check("rst_mem_data", mem_data, 32'h0);
      check("rst_mem_byte_en", 32'(mem_byte_en), 32'h0);
      check_query("rst");
      check_state("rst");
      @(negedge clock);
      reset = 1'b0;

      // Single store into an empty buffer, then a one-cycle ack.
      drive(1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 1'b0);
      tick("single_push");
      check("single_mem_req", 32'(mem_req), 32'd1);
      check("single_mem_address", mem_address, 32'h100);
      check("single_count", 32'(count), 32'd1);
      drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
      tick("single_pop");
      check("single_empty", 32'(empty), 32'd1);

      // Fill, try to overfill, then push+ack while full.
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b1, 32'h1000 + 32'(i * 4), 32'hA0 + 32'(i), 4'hF, 1'b0);
         tick("fill");
      end
      check("fill_full", 32'(full), 32'd1);
      check("fill_st_ready", 32'(st_ready), 32'd0);
      drive(1'b1, 32'h2000, 32'hBAD, 4'hF, 1'b0);
      tick("overfill");
      check("overfill_count", 32'(count), 32'(DEPTH));
      drive(1'b1, 32'h2004, 32'hBAD, 4'hF, 1'b1);
      tick("full_push_ack");
      check("full_push_ack_count", 32'(count), 32'(DEPTH - 1));
      drain("fill_drain");

      // Youngest full-word match wins.
      drive(1'b1, 32'h200, 32'h11111111, 4'hF, 1'b0);
      tick("fwd_a");
      drive(1'b1, 32'h200, 32'h22222222, 4'hF, 1'b0);
      query(1'b1, 32'h203);
      #1;
      check_query("fwd_same_cycle");
      tick("fwd_b");
      #1;
      check("fwd_ld_hit", 32'(ld_hit), 32'd1);
      check("fwd_ld_data", ld_data, 32'h22222222);
      check("fwd_ld_stall", 32'(ld_stall), 32'd0);
      drain("fwd_drain");

      // Partial byte enables force a stall; a different word is a plain miss.
      drive(1'b1, 32'h300, 32'hAABBCCDD, 4'b0011, 1'b0);
      tick("partial_push");
      drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      query(1'b1, 32'h300);
      #1;
      check("partial_ld_stall", 32'(ld_stall), 32'd1);
      check("partial_ld_hit", 32'(ld_hit), 32'd0);
      query(1'b1, 32'h304);
      #1;
      check("miss_ld_stall", 32'(ld_stall), 32'd0);
      check("miss_ld_hit", 32'(ld_hit), 32'd0);
      query(1'b1, 32'h300);
      mem_ack = 1'b1;
      #1;
      check("pop_visible_stall", 32'(ld_stall), 32'd1);
      tick("partial_pop");
      mem_ack = 1'b0;

      // Same-word stores behind a stalled head: merged or separate depending on build.
      drive(1'b1, 32'h400, 32'h12345678, 4'hF, 1'b0);
      tick("coal_a");
      drive(1'b1, 32'h500, 32'h000000AA, 4'b0001, 1'b0);
      tick("coal_b");
      drive(1'b1, 32'h500, 32'h0000BB00, 4'b0010, 1'b0);
      tick("coal_c");
      drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
      tick("coal_pop");
      mem_ack = 1'b0;
`ifdef STORE_BUFFER_COALESCE_EN
      check("coal_count", 32'(count), 32'd1);
      check("coal_mem_data", mem_data, 32'h0000BBAA);
      check("coal_mem_byte_en", 32'(mem_byte_en), 32'h3);
`else
      check("coal_count", 32'(count), 32'd2);
      check("coal_mem_data", mem_data, 32'h000000AA);
      check("coal_mem_byte_en", 32'(mem_byte_en), 32'h1);
`endif
      drain("coal_drain");

      // Random traffic over a few words with per-cycle query checks.
      for (int n = 0; n < 80; n++) begin
         drive(1'($urandom_range(0, 1)), 32'h600 + 32'($urandom_range(0, 2) * 4),
               $urandom, ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF,
               1'($urandom_range(0, 2) == 0));
         query(1'($urandom_range(0, 3) != 0), 32'h600 + 32'($urandom_range(0, 3) * 4));
         #1;
         check_query("rnd");
         tick("rnd");
      end
      query(1'b0, 32'h0);
      drain("rnd_drain");

      // Asynchronous reset in the middle of a drain.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h700 + 32'(i * 4), 32'hC0 + 32'(i), 4'hF, 1'b0);
         tick("rst_fill");
      end
      drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
      query(1'b1, 32'h704);
      #2;
      check("mid_mem_req", 32'(mem_req), 32'd1);
      check("mid_ld_hit", 32'(ld_hit), 32'd1);
      reset = 1'b1;
      #1;
      check("async_mem_req", 32'(mem_req), 32'd0);
      check("async_count", 32'(count), 32'd0);
      check("async_ld_hit", 32'(ld_hit), 32'd0);
      check("async_mem_address", mem_address, 32'h0);
      sb.delete();
      @(negedge clock);
      reset   = 1'b0;
      mem_ack = 1'b0;
      #1;
      check("post_rst_st_ready", 32'(st_ready), 32'd1);
      check("post_rst_empty", 32'(empty), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
